decode_operand_stage: RTL and testbench
=======================================

DECODE_OPERAND_STAGE -- requirements
Module: decode_operand_stage

Interface
REQ-001 Parameter DATA_W, default 32, is the datapath and register width in bits.
REQ-002 Parameter NREGS, default 32, is the number of architectural registers; AW = clog2(NREGS).
REQ-003 Parameter SP_REG, default 29, is the stack-pointer register index.
REQ-004 Parameter SP_INIT, default 0, is the SP value after reset.
REQ-005 One clock; reset is synchronous and active-high; ports are named clk and rst.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 rst  in  1  synchronous active-high reset.
REQ-008 in_valid  in  1  a decoded instruction is presented.
REQ-009 in_ready  out  1  the stage accepts the instruction this cycle.
REQ-010 rd, rs, rt  in  AW each  instruction register fields.
REQ-011 shamt  in  5  shift amount.
REQ-012 i_imm  in  16  I-type immediate field.
REQ-013 j_imm  in  26  J-type immediate field.
REQ-014 pc  in  DATA_W  PC of the instruction.
REQ-015 alu_src  in  2  operand mode: 00 reg/reg, 01 reg/imm, 10 reg/shamt, 11 zero/zero.
REQ-016 branch, sp_op, reg2_sel, sext_sel, is_load, wr_en  in  1 each  decode controls.
REQ-017 fwd_valid, fwd_reg, fwd_data  in  1/AW/DATA_W  EX/MEM forwarding result.
REQ-018 wb_we, wb_reg, wb_data  in  1/AW/DATA_W  register-file write port.
REQ-019 out_valid  out  1; out_ready  in  1  downstream handshake.
REQ-020 alu_a, alu_b  out  DATA_W  registered ALU operands.
REQ-021 out_dest  out  AW; out_wr_en, out_load  out  1 each  registered destination info.

Function
REQ-022 A transfer in or out occurs only on a cycle where valid and ready are both 1; out_* fields SHALL hold while out_valid=1 and out_ready=0.
REQ-023 in_ready = (!out_valid | out_ready) & !hazard; latency from accepted input to out_valid is exactly 1 cycle.
REQ-024 Read port 1 index = SP_REG if sp_op, else rs; read port 2 index = rt if reg2_sel, else rd.
REQ-025 Register 0 SHALL always read as zero, and writes to it SHALL be ignored.
REQ-026 Operand priority per read port: fwd_data if fwd_valid and fwd_reg matches a non-zero index; else wb_data if wb_we and wb_reg matches; else the register-file contents.
REQ-027 The immediate is j_imm sign-extended to DATA_W if sext_sel, else i_imm sign-extended to DATA_W.
REQ-028 alu_src 00: alu_a=R1, alu_b=R2.
REQ-029 alu_src 01: alu_a = pc if branch, else R1; alu_b = immediate.
REQ-030 alu_src 10: alu_a=R1; alu_b = 1 if sp_op, else zero-extended shamt.
REQ-031 alu_src 11: alu_a=0, alu_b=0.
REQ-032 hazard = out_valid & out_load & out_wr_en & (out_dest != 0) & out_dest equals a read index used by the mode (port 2 is unused in modes 01 and 11).
REQ-033 While hazard=1 and out_ready=1, the stage SHALL drop out_valid (bubble) for one cycle and then accept the stalled instruction.
REQ-034 The register file is written on the clock edge when wb_we=1; the register file write and an output update on the same cycle SHALL both take effect.

Reset
REQ-035 On rst: out_valid=0; alu_a, alu_b, out_dest, out_wr_en and out_load are 0; all registers are 0 except SP_REG=SP_INIT.
REQ-036 rst asserted mid-stall SHALL discard the held output and the stalled instruction; in_ready=1 on the first cycle after rst deasserts.

Structure
REQ-037 The alu_src encodings and the operand-mode constants SHALL live in the shared package cpu_pkg.
REQ-038 The register file SHALL be the sub-module regfile_2r1w (2 asynchronous reads, 1 synchronous write, parametrised DATA_W and NREGS).

Verification
REQ-039 Scenario: wb writes r5=0x1234; the next cycle issues ADD r1,r5,r5 (mode 00) -> alu_a = alu_b = 0x1234.
REQ-040 Scenario: fwd_valid, fwd_reg=5, fwd_data=0xAA while wb_we, wb_reg=5, wb_data=0xBB -> operands = 0xAA.
REQ-041 Scenario: LW r3 accepted, then ADD using r3 -> one bubble cycle, then ADD issues with the forwarded value.
REQ-042 Scenario: mode 01, branch=1, pc=0x100, i_imm=0xFFFE -> alu_a=0x100, alu_b=0xFFFFFFFE.
REQ-043 Scenario: PUSH (sp_op=1, mode 10) after reset with SP_INIT=0x3FF -> alu_a=0x3FF, alu_b=1.
REQ-044 Scenario: out_ready=0 for 3 cycles -> outputs stable, in_ready=0; a write to r0 leaves r0 reading 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared operand-mode encodings for the decode/operand stage
// Purpose: alu_src operand-mode enumeration and helpers used by decode_operand_stage.
// Contents: alu_src_e (operand modes), mode_reads_port2() (hazard scoping).
package cpu_pkg;

  typedef enum logic [1:0] {
    ALU_SRC_REG_REG   = 2'b00,  // alu_a=R1, alu_b=R2
    ALU_SRC_REG_IMM   = 2'b01,  // alu_a=pc or R1, alu_b=immediate
    ALU_SRC_REG_SHAMT = 2'b10,  // alu_a=R1, alu_b=1 (sp_op) or shamt
    ALU_SRC_ZERO      = 2'b11   // alu_a=0, alu_b=0
  } alu_src_e;

  localparam int SHAMT_W = 5;
  localparam int I_IMM_W = 16;
  localparam int J_IMM_W = 26;

  // Read port 2 is only considered live in the reg/reg and reg/shamt modes.
  function automatic logic mode_reads_port2(alu_src_e mode);
    return (mode == ALU_SRC_REG_REG) || (mode == ALU_SRC_REG_SHAMT);
  endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// rtl/regfile_2r1w.sv - register file, 2 asynchronous reads, 1 synchronous write
// Purpose: architectural register storage; r0 is hardwired to zero.
// Ports: clk, rst (sync active-high); raddr1_i/rdata1_o, raddr2_i/rdata2_o (async reads);
//        we_i, waddr_i, wdata_i (write on rising edge).
module regfile_2r1w #(
  parameter int                DATA_W  = 32,
  parameter int                NREGS   = 32,
  parameter int                SP_REG  = 29,
  parameter logic [DATA_W-1:0] SP_INIT = '0,
  localparam int               AW      = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [AW-1:0]     raddr1_i,
  output logic [DATA_W-1:0] rdata1_o,
  input  logic [AW-1:0]     raddr2_i,
  output logic [DATA_W-1:0] rdata2_o,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i
);

  logic [DATA_W-1:0] regs_q [NREGS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= (i == SP_REG) ? SP_INIT : '0;
      end
    end else if (we_i && (waddr_i != '0)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  // r0 is forced to zero on read so its storage never matters.
  assign rdata1_o = (raddr1_i == '0) ? '0 : regs_q[raddr1_i];
  assign rdata2_o = (raddr2_i == '0) ? '0 : regs_q[raddr2_i];

endmodule

// File: rtl/decode_operand_stage.sv
// rtl/decode_operand_stage.sv - operand fetch/select stage with bypass and load-use stall
// Purpose: reads two source registers (with EX/MEM and writeback bypass), builds the
//          ALU operands for the selected mode and registers them behind a valid/ready
//          handshake; stalls one cycle on a load-use hazard.
// Ports: clk, rst; in_valid/in_ready + decoded fields (rd, rs, rt, shamt, i_imm, j_imm,
//        pc, alu_src, branch, sp_op, reg2_sel, sext_sel, is_load, wr_en);
//        fwd_valid/fwd_reg/fwd_data; wb_we/wb_reg/wb_data;
//        out_valid/out_ready, alu_a, alu_b, out_dest, out_wr_en, out_load.
module decode_operand_stage
  import cpu_pkg::*;
#(
  parameter int                DATA_W  = 32,
  parameter int                NREGS   = 32,
  parameter int                SP_REG  = 29,
  parameter logic [DATA_W-1:0] SP_INIT = '0,
  localparam int               AW      = $clog2(NREGS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [AW-1:0]      rd,
  input  logic [AW-1:0]      rs,
  input  logic [AW-1:0]      rt,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [I_IMM_W-1:0] i_imm,
  input  logic [J_IMM_W-1:0] j_imm,
  input  logic [DATA_W-1:0]  pc,
  input  logic [1:0]         alu_src,
  input  logic               branch,
  input  logic               sp_op,
  input  logic               reg2_sel,
  input  logic               sext_sel,
  input  logic               is_load,
  input  logic               wr_en,
  input  logic               fwd_valid,
  input  logic [AW-1:0]      fwd_reg,
  input  logic [DATA_W-1:0]  fwd_data,
  input  logic               wb_we,
  input  logic [AW-1:0]      wb_reg,
  input  logic [DATA_W-1:0]  wb_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  alu_a,
  output logic [DATA_W-1:0]  alu_b,
  output logic [AW-1:0]      out_dest,
  output logic               out_wr_en,
  output logic               out_load
);

  localparam logic [AW-1:0] SP_IDX = AW'(SP_REG);

  alu_src_e          mode;
  logic [AW-1:0]     ra1, ra2;
  logic [DATA_W-1:0] rf_rd1, rf_rd2;
  logic [DATA_W-1:0] r1, r2, imm;
  logic [DATA_W-1:0] alu_a_d, alu_b_d;
  logic              hazard, accept;

  logic              out_valid_q, out_wr_en_q, out_load_q;
  logic [DATA_W-1:0] alu_a_q, alu_b_q;
  logic [AW-1:0]     out_dest_q;

  assign mode = alu_src_e'(alu_src);
  assign ra1  = sp_op ? SP_IDX : rs;
  assign ra2  = reg2_sel ? rt : rd;

  regfile_2r1w #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS),
    .SP_REG (SP_REG),
    .SP_INIT(SP_INIT)
  ) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .raddr1_i(ra1),
    .rdata1_o(rf_rd1),
    .raddr2_i(ra2),
    .rdata2_o(rf_rd2),
    .we_i    (wb_we),
    .waddr_i (wb_reg),
    .wdata_i (wb_data)
  );

  // EX/MEM result is younger than the writeback value, so it wins; index 0 is never bypassed.
  always_comb begin
    r1 = rf_rd1;
    if (ra1 != '0) begin
      if (fwd_valid && (fwd_reg == ra1))   r1 = fwd_data;
      else if (wb_we && (wb_reg == ra1))   r1 = wb_data;
    end
    r2 = rf_rd2;
    if (ra2 != '0) begin
      if (fwd_valid && (fwd_reg == ra2))   r2 = fwd_data;
      else if (wb_we && (wb_reg == ra2))   r2 = wb_data;
    end
  end

  assign imm = sext_sel ? {{(DATA_W-J_IMM_W){j_imm[J_IMM_W-1]}}, j_imm}
                        : {{(DATA_W-I_IMM_W){i_imm[I_IMM_W-1]}}, i_imm};

  always_comb begin
    alu_a_d = '0;
    alu_b_d = '0;
    case (mode)
      ALU_SRC_REG_REG: begin
        alu_a_d = r1;
        alu_b_d = r2;
      end
      ALU_SRC_REG_IMM: begin
        alu_a_d = branch ? pc : r1;
        alu_b_d = imm;
      end
      ALU_SRC_REG_SHAMT: begin
        alu_a_d = r1;
        alu_b_d = sp_op ? {{(DATA_W-1){1'b0}}, 1'b1} : {{(DATA_W-SHAMT_W){1'b0}}, shamt};
      end
      default: begin
        alu_a_d = '0;
        alu_b_d = '0;
      end
    endcase
  end

  // A load sitting in the output register cannot be forwarded yet: hold the consumer
  // for one cycle so its value arrives on fwd_* once the load has moved on.
  assign hazard = out_valid_q && out_load_q && out_wr_en_q && (out_dest_q != '0) &&
                  ((out_dest_q == ra1) || (mode_reads_port2(mode) && (out_dest_q == ra2)));

  assign in_ready = (!out_valid_q || out_ready) && !hazard;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      out_dest_q  <= '0;
      out_wr_en_q <= 1'b0;
      out_load_q  <= 1'b0;
    end else if (!out_valid_q || out_ready) begin
      // A hazard with out_ready=1 leaves accept=0 here, which inserts the bubble.
      out_valid_q <= accept;
      if (accept) begin
        alu_a_q     <= alu_a_d;
        alu_b_q     <= alu_b_d;
        out_dest_q  <= rd;
        out_wr_en_q <= wr_en;
        out_load_q  <= is_load;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign out_dest  = out_dest_q;
  assign out_wr_en = out_wr_en_q;
  assign out_load  = out_load_q;

endmodule

// File: tb/tb_decode_operand_stage.sv
// tb/tb_decode_operand_stage.sv - self-checking bench for decode_operand_stage
module tb_decode_operand_stage;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, in_ready;
  logic [4:0]  rd, rs, rt, shamt;
  logic [15:0] i_imm;
  logic [25:0] j_imm;
  logic [31:0] pc;
  logic [1:0]  alu_src;
  logic        branch, sp_op, reg2_sel, sext_sel, is_load, wr_en;
  logic        fwd_valid, wb_we;
  logic [4:0]  fwd_reg, wb_reg;
  logic [31:0] fwd_data, wb_data;
  logic        out_valid, out_ready, out_wr_en, out_load;
  logic [31:0] alu_a, alu_b;
  logic [4:0]  out_dest;

  decode_operand_stage #(
    .DATA_W(32), .NREGS(32), .SP_REG(29), .SP_INIT(32'h3FF)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .rd(rd), .rs(rs), .rt(rt), .shamt(shamt), .i_imm(i_imm), .j_imm(j_imm), .pc(pc),
    .alu_src(alu_src), .branch(branch), .sp_op(sp_op), .reg2_sel(reg2_sel),
    .sext_sel(sext_sel), .is_load(is_load), .wr_en(wr_en),
    .fwd_valid(fwd_valid), .fwd_reg(fwd_reg), .fwd_data(fwd_data),
    .wb_we(wb_we), .wb_reg(wb_reg), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .alu_a(alu_a), .alu_b(alu_b),
    .out_dest(out_dest), .out_wr_en(out_wr_en), .out_load(out_load)
  );

  typedef struct packed {
    logic [1:0]  src;
    logic [4:0]  rd, rs, rt, shamt;
    logic [15:0] iimm;
    logic [25:0] jimm;
    logic [31:0] pc;
    logic        br, sp, r2, sx, ld, we;
    logic        fv;
    logic [4:0]  fr;
    logic [31:0] fd;
    logic        wv;
    logic [4:0]  wr;
    logic [31:0] wd;
    logic [31:0] ea, eb;
  } vec_t;

  typedef struct packed {
    logic [31:0] a, b;
    logic [4:0]  dest;
    logic        we, ld;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_checks = 0;
  int   n_err    = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic clear_in();
    in_valid = 1'b0; rd = '0; rs = '0; rt = '0; shamt = '0; i_imm = '0; j_imm = '0;
    pc = '0; alu_src = '0; branch = 1'b0; sp_op = 1'b0; reg2_sel = 1'b0;
    sext_sel = 1'b0; is_load = 1'b0; wr_en = 1'b0;
    fwd_valid = 1'b0; fwd_reg = '0; fwd_data = '0;
    wb_we = 1'b0; wb_reg = '0; wb_data = '0;
  endtask

  task automatic apply(input vec_t v);
    alu_src = v.src; rd = v.rd; rs = v.rs; rt = v.rt; shamt = v.shamt;
    i_imm = v.iimm; j_imm = v.jimm; pc = v.pc; branch = v.br; sp_op = v.sp;
    reg2_sel = v.r2; sext_sel = v.sx; is_load = v.ld; wr_en = v.we;
    fwd_valid = v.fv; fwd_reg = v.fr; fwd_data = v.fd;
    wb_we = v.wv; wb_reg = v.wr; wb_data = v.wd;
  endtask

  // Presents v until accepted; reports stall cycles and out_valid at the accepting cycle.
  task automatic issue(input vec_t v, output int waited, output logic ov_acc);
    bit done;
    apply(v);
    in_valid = 1'b1;
    waited = 0; ov_acc = 1'b0; done = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        done = 1'b1;
        ov_acc = out_valid;
        sb.push_back({v.ea, v.eb, v.rd, v.we, v.ld});
      end else begin
        waited++;
        if (waited >= 20) begin
          n_checks++; n_err++;
          $display("FAIL issue_timeout: got in_ready=0 for %0d cycles expected accept", waited);
          done = 1'b1;
        end
      end
    end
    @(posedge clk); #1;
    clear_in();
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_checks++; n_err++;
        $display("FAIL unexpected_output: got alu_a=%h alu_b=%h expected none", alu_a, alu_b);
      end else begin
        e = sb.pop_front();
        chk("alu_a", alu_a, e.a);
        chk("alu_b", alu_b, e.b);
        chk("out_dest", 32'(out_dest), 32'(e.dest));
        chk("out_ctl", {30'b0, out_wr_en, out_load}, {30'b0, e.we, e.ld});
      end
    end
  end

  vec_t vecs[14];
  vec_t v;
  int   w;
  logic ov;

  initial begin
    // Register state is tracked by hand: SP=0x3FF after reset, then r5 and r6 get written.
    v = '0; v.src = 2'b10; v.rd = 5'd29; v.sp = 1'b1; v.we = 1'b1; v.ea = 32'h3FF; v.eb = 32'h1; vecs[0] = v;
    v = '0; v.src = 2'b11; v.rs = 5'd5; v.rt = 5'd5; v.wv = 1'b1; v.wr = 5'd5; v.wd = 32'h1234; vecs[1] = v;
    v = '0; v.src = 2'b00; v.rd = 5'd1; v.rs = 5'd5; v.rt = 5'd5; v.r2 = 1'b1; v.we = 1'b1; v.ea = 32'h1234; v.eb = 32'h1234; vecs[2] = v;
    v = '0; v.src = 2'b00; v.rd = 5'd2; v.rs = 5'd5; v.rt = 5'd5; v.r2 = 1'b1; v.fv = 1'b1; v.fr = 5'd5; v.fd = 32'hAA;
    v.wv = 1'b1; v.wr = 5'd5; v.wd = 32'hBB; v.ea = 32'hAA; v.eb = 32'hAA; vecs[3] = v;
    v = '0; v.src = 2'b00; v.rd = 5'd6; v.rs = 5'd5; v.wv = 1'b1; v.wr = 5'd6; v.wd = 32'h66; v.ea = 32'hBB; v.eb = 32'h66; vecs[4] = v;
    v = '0; v.src = 2'b01; v.rs = 5'd5; v.br = 1'b1; v.pc = 32'h100; v.iimm = 16'hFFFE; v.ea = 32'h100; v.eb = 32'hFFFFFFFE; vecs[5] = v;
    v = '0; v.src = 2'b01; v.rs = 5'd6; v.sx = 1'b1; v.jimm = 26'h2000000; v.iimm = 16'h0001; v.ea = 32'h66; v.eb = 32'hFE000000; vecs[6] = v;
    v = '0; v.src = 2'b01; v.rs = 5'd0; v.iimm = 16'h7FFF; v.jimm = 26'h3FFFFFF; v.ea = 32'h0; v.eb = 32'h7FFF; vecs[7] = v;
    v = '0; v.src = 2'b10; v.rs = 5'd6; v.shamt = 5'd31; v.ea = 32'h66; v.eb = 32'd31; vecs[8] = v;
    v = '0; v.src = 2'b11; v.rs = 5'd6; v.rt = 5'd5; v.br = 1'b1; v.pc = 32'h200; v.iimm = 16'h1234; v.ea = 32'h0; v.eb = 32'h0; vecs[9] = v;
    v = '0; v.src = 2'b00; v.r2 = 1'b1; v.fv = 1'b1; v.fr = 5'd0; v.fd = 32'hFF; v.wv = 1'b1; v.wr = 5'd0; v.wd = 32'h77; vecs[10] = v;
    v = '0; v.src = 2'b00; v.rs = 5'd0; v.rt = 5'd6; v.r2 = 1'b1; v.ea = 32'h0; v.eb = 32'h66; vecs[11] = v;
    v = '0; v.src = 2'b00; v.rs = 5'd6; v.rd = 5'd5; v.fv = 1'b1; v.fr = 5'd5; v.fd = 32'hCC; v.ea = 32'h66; v.eb = 32'hCC; vecs[12] = v;
    v = '0; v.src = 2'b00; v.rs = 5'd6; v.rt = 5'd5; v.r2 = 1'b1; v.sp = 1'b1; v.ea = 32'h3FF; v.eb = 32'hBB; vecs[13] = v;

    clear_in();
    out_ready = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_b", alu_b, 32'd0);
    chk("rst_dest", 32'(out_dest), 32'd0);
    chk("rst_ctl", {30'b0, out_wr_en, out_load}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    for (int i = 0; i < 14; i++) begin
      issue(vecs[i], w, ov);
      chk($sformatf("vec%0d_nostall", i), 32'(w), 32'd0);
    end
    idle(3);

    // Load-use on port 1: one bubble, then the consumer sees the forwarded load value.
    v = '0; v.src = 2'b01; v.rd = 5'd3; v.iimm = 16'h8; v.ld = 1'b1; v.we = 1'b1; v.ea = 32'h0; v.eb = 32'h8;
    issue(v, w, ov);
    v = '0; v.src = 2'b00; v.rd = 5'd4; v.rs = 5'd3; v.rt = 5'd3; v.r2 = 1'b1; v.we = 1'b1;
    v.fv = 1'b1; v.fr = 5'd3; v.fd = 32'h55; v.ea = 32'h55; v.eb = 32'h55;
    issue(v, w, ov);
    chk("lu_stall_cycles", 32'(w), 32'd1);
    chk("lu_bubble", 32'(ov), 32'd0);

    // Load dest matches only port 2, which mode 01 does not read: no stall.
    v = '0; v.src = 2'b01; v.rd = 5'd7; v.iimm = 16'h4; v.ld = 1'b1; v.we = 1'b1; v.ea = 32'h0; v.eb = 32'h4;
    issue(v, w, ov);
    v = '0; v.src = 2'b01; v.rd = 5'd7; v.rs = 5'd6; v.iimm = 16'h1; v.ea = 32'h66; v.eb = 32'h1;
    issue(v, w, ov);
    chk("imm_no_stall", 32'(w), 32'd0);

    // Load-use through port 2 in mode 00.
    v = '0; v.src = 2'b01; v.rd = 5'd8; v.iimm = 16'hC; v.ld = 1'b1; v.we = 1'b1; v.ea = 32'h0; v.eb = 32'hC;
    issue(v, w, ov);
    v = '0; v.src = 2'b00; v.rd = 5'd8; v.rs = 5'd6; v.fv = 1'b1; v.fr = 5'd8; v.fd = 32'h88; v.ea = 32'h66; v.eb = 32'h88;
    issue(v, w, ov);
    chk("lu2_stall_cycles", 32'(w), 32'd1);
    idle(3);

    // Back-pressure for 3 cycles while r0 is written.
    out_ready = 1'b0;
    v = '0; v.src = 2'b01; v.rd = 5'd9; v.rs = 5'd6; v.iimm = 16'h10; v.we = 1'b1; v.ea = 32'h66; v.eb = 32'h10;
    issue(v, w, ov);
    wb_we = 1'b1; wb_reg = 5'd0; wb_data = 32'hDEAD;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_alu_a", alu_a, 32'h66);
      chk("bp_alu_b", alu_b, 32'h10);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk); #1;
    clear_in();
    out_ready = 1'b1;
    v = '0; v.src = 2'b00; v.r2 = 1'b1; v.ea = 32'h0; v.eb = 32'h0;
    issue(v, w, ov);
    idle(3);

    // Reset during a stall discards both held output and stalled input.
    out_ready = 1'b0;
    v = '0; v.src = 2'b00; v.rs = 5'd6; v.ea = 32'h66; v.eb = 32'h0;
    issue(v, w, ov);
    v = '0; v.src = 2'b00; v.rs = 5'd5; apply(v); in_valid = 1'b1;
    @(negedge clk);
    chk("stall_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b1;
    clear_in();
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    out_ready = 1'b1;
    @(negedge clk);
    chk("post_rst_out_valid", 32'(out_valid), 32'd0);
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    v = '0; v.src = 2'b00; v.rs = 5'd5; v.rt = 5'd6; v.r2 = 1'b1; v.ea = 32'h0; v.eb = 32'h0;
    issue(v, w, ov);
    v = '0; v.src = 2'b10; v.rd = 5'd29; v.sp = 1'b1; v.we = 1'b1; v.ea = 32'h3FF; v.eb = 32'h1;
    issue(v, w, ov);
    idle(3);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
